// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-fetch block: the NOP word,
// the fetch error codes and the registered response record.
package imem_pkg;

    // Word returned whenever a fetch reports an error.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Fetch error codes presented on Err alongside Valid.
    typedef enum logic [1:0] {
        ERR_OK        = 2'b00,
        ERR_MISALIGN  = 2'b01,
        ERR_RANGE     = 2'b10,
        ERR_UNWRITTEN = 2'b11
    } err_e;

    // One completed fetch as held in the output register.
    typedef struct packed {
        logic [31:0] inst;
        err_e        err;
    } fetch_rsp_t;

    // Response value held by the output register while reset is asserted.
    localparam fetch_rsp_t RSP_IDLE = '{inst: NOP, err: ERR_OK};

    // Resolve the error code for one fetch. Misalignment dominates range,
    // and range dominates the unwritten check: an out-of-range index aliases
    // onto a real word whose written bit says nothing about this address.
    function automatic err_e classify(input logic misalign,
                                      input logic out_of_range,
                                      input logic written);
        if (misalign)          return ERR_MISALIGN;
        else if (out_of_range) return ERR_RANGE;
        else if (!written)     return ERR_UNWRITTEN;
        else                   return ERR_OK;
    endfunction

    // Build the response record; an erroring fetch always carries NOP so
    // that stale or uninitialised storage never reaches Inst.
    function automatic fetch_rsp_t make_rsp(input err_e        err,
                                            input logic [31:0] word);
        fetch_rsp_t rsp;
        rsp.err  = err;
        rsp.inst = (err == ERR_OK) ? word : NOP;
        return rsp;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port for program load, one
// combinational read port with write-first bypass, and a per-word written
// bit that is cleared by reset while the data words themselves are not.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    output logic          rwritten
);

    logic [31:0]      mem [DEPTH];
    logic [DEPTH-1:0] written;

    // Program-load write into the data array.
    // NOTE: the data array has no reset; validity is tracked separately by
    // the written bits, which keeps the array mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Per-word written flags: set on load, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
        end else if (we) begin
            written[waddr] <= 1'b1;
        end
    end

    // Combinational read; a same-cycle write to the read word wins.
    // NOTE: both outputs get a default before the override so no latch forms.
    always_comb begin
        rdata    = mem[raddr];
        rwritten = written[raddr];
        if (we && (waddr == raddr)) begin
            rdata    = wdata;
            rwritten = 1'b1;
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch front end: accepts a byte-addressed fetch when not
// stalled or flushed, classifies alignment/range/written errors and presents
// the result one cycle later from a stall-holding output register.
module imem_fetch
    import imem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          Req,
    input  logic [31:0]   Addr,
    input  logic          Stall,
    input  logic          Flush,
    output logic          Ready,
    output logic [31:0]   Inst,
    output logic          Valid,
    output logic [1:0]    Err,
    input  logic          PWe,
    input  logic [AW-1:0] PAddr,
    input  logic [31:0]   PData
);

    logic          accept;
    logic [AW-1:0] word_idx;
    logic          misalign;
    logic          out_of_range;
    logic [31:0]   rd_word;
    logic          rd_written;
    fetch_rsp_t    rsp_next;
    fetch_rsp_t    rsp_q;
    logic          valid_q;

    // Ready depends only on Stall, so it stays meaningful through reset.
    assign Ready  = ~Stall;
    assign accept = Req & Ready & ~Flush;

    assign word_idx     = Addr[AW+1:2];
    assign misalign     = |Addr[1:0];
    assign out_of_range = |Addr[31:AW+2];

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk      (Clk),
        .rst_n    (Clrn),
        .we       (PWe),
        .waddr    (PAddr),
        .wdata    (PData),
        .raddr    (word_idx),
        .rdata    (rd_word),
        .rwritten (rd_written)
    );

    assign rsp_next = make_rsp(classify(misalign, out_of_range, rd_written), rd_word);

    // Output register: flush kills, stall holds, otherwise capture or idle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            valid_q <= 1'b0;
            rsp_q   <= RSP_IDLE;
        end else if (Flush) begin
            valid_q <= 1'b0;
        end else if (!Stall) begin
            valid_q <= Req;
            if (accept) begin
                rsp_q <= rsp_next;
            end
        end
    end

    assign Valid = valid_q;
    assign Inst  = rsp_q.inst;
    assign Err   = rsp_q.err;

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: stimulus pushes hand-computed responses,
// an independent monitor tracks the expected output register and compares.
`timescale 1ns/1ps
module tb_imem_fetch;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          Clk = 1'b0;
    logic          Clrn;
    logic          Req;
    logic [31:0]   Addr;
    logic          Stall;
    logic          Flush;
    logic          Ready;
    logic [31:0]   Inst;
    logic          Valid;
    logic [1:0]    Err;
    logic          PWe;
    logic [AW-1:0] PAddr;
    logic [31:0]   PData;

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    imem_fetch #(.DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Clrn  (Clrn),
        .Req   (Req),
        .Addr  (Addr),
        .Stall (Stall),
        .Flush (Flush),
        .Ready (Ready),
        .Inst  (Inst),
        .Valid (Valid),
        .Err   (Err),
        .PWe   (PWe),
        .PAddr (PAddr),
        .PData (PData)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one fetch cycle and record the response it must produce.
    task automatic fetch(input logic [31:0] a, input logic [31:0] inst, input logic [1:0] err);
        exp_t e;
        @(negedge Clk);
        Req = 1'b1; Addr = a; Stall = 1'b0; Flush = 1'b0; PWe = 1'b0;
        e.inst = inst; e.err = err;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Req = 1'b0; Stall = 1'b0; Flush = 1'b0; PWe = 1'b0;
        end
    endtask

    task automatic load(input logic [AW-1:0] idx, input logic [31:0] data);
        @(negedge Clk);
        Req = 1'b0; PWe = 1'b1; PAddr = idx; PData = data;
        @(negedge Clk);
        PWe = 1'b0;
    endtask

    // Monitor: model the output register from the bench-driven inputs and
    // compare every cycle; accepted fetches consume scoreboard entries.
    initial begin : monitor
        logic        s_req, s_stall, s_flush, s_rst;
        logic        ev;
        logic [31:0] ei;
        logic [1:0]  ee;
        exp_t        e;
        ev = 1'b0; ei = 32'h0; ee = 2'b00;
        forever begin
            @(posedge Clk);
            s_req = Req; s_stall = Stall; s_flush = Flush; s_rst = Clrn;
            #1;
            if (!s_rst || s_flush) begin
                ev = 1'b0;
            end else if (s_stall) begin
                ev = ev;
            end else if (s_req) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underflow: fetch accepted with no expected entry at %0t", $time);
                    ev = 1'b0;
                end else begin
                    e  = sb.pop_front();
                    ei = e.inst; ee = e.err; ev = 1'b1;
                end
            end else begin
                ev = 1'b0;
            end
            check("valid", {31'b0, Valid}, {31'b0, ev});
            if (ev) begin
                check("inst", Inst, ei);
                check("err", {30'b0, Err}, {30'b0, ee});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        Clrn = 1'b0; Req = 1'b0; Addr = 32'h0; Stall = 1'b0; Flush = 1'b0;
        PWe = 1'b0; PAddr = '0; PData = 32'h0;
        #2;
        check("rst_valid", {31'b0, Valid}, 32'd0);
        check("rst_inst", Inst, 32'h0);
        check("rst_err", {30'b0, Err}, 32'd0);
        check("rst_ready", {31'b0, Ready}, 32'd1);
        @(negedge Clk);
        @(negedge Clk);
        Clrn = 1'b1;

        // Basic load and back-to-back fetch.
        load(5'd0, 32'h2001_0008);
        load(5'd1, 32'h3402_000C);
        fetch(32'h0, 32'h2001_0008, 2'b00);
        fetch(32'h4, 32'h3402_000C, 2'b00);
        idle(1);

        // Error classification and priority.
        fetch(32'h6,  32'h0, 2'b01);
        fetch(32'h80, 32'h0, 2'b10);
        fetch(32'h14, 32'h0, 2'b11);
        fetch(32'h81, 32'h0, 2'b01);
        fetch(32'h87, 32'h0, 2'b01);
        idle(2);

        // Stall holds the output register; Ready tracks Stall.
        load(5'd2, 32'h0022_1820);
        fetch(32'h8, 32'h0022_1820, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            Stall = 1'b1; Req = 1'b1; Addr = 32'h4;
            #1;
            check("stall_ready", {31'b0, Ready}, 32'd0);
        end
        fetch(32'h0, 32'h2001_0008, 2'b00);
        #1;
        check("unstall_ready", {31'b0, Ready}, 32'd1);

        // Flush with Req and Stall: Valid drops, nothing accepted.
        @(negedge Clk);
        Flush = 1'b1; Req = 1'b1; Stall = 1'b1; Addr = 32'h4;
        @(negedge Clk);
        Flush = 1'b1; Req = 1'b1; Stall = 1'b0; Addr = 32'h4;
        idle(2);

        // Write-first bypass on the same word in the same cycle.
        begin
            exp_t e;
            @(negedge Clk);
            PWe = 1'b1; PAddr = 5'd13; PData = 32'hAD02_000C;
            Req = 1'b1; Addr = 32'h34; Stall = 1'b0; Flush = 1'b0;
            e.inst = 32'hAD02_000C; e.err = 2'b00;
            sb.push_back(e);
        end
        fetch(32'h34, 32'hAD02_000C, 2'b00);
        idle(2);

        // Mid-stream reset: Valid held high by stall, then reset kills it.
        fetch(32'h4, 32'h3402_000C, 2'b00);
        @(negedge Clk);
        Req = 1'b0; Stall = 1'b1;
        #2;
        Clrn = 1'b0;
        #1;
        check("midrst_valid", {31'b0, Valid}, 32'd0);
        check("midrst_inst", Inst, 32'h0);
        check("midrst_err", {30'b0, Err}, 32'd0);
        @(negedge Clk);
        Clrn = 1'b1; Stall = 1'b0;
        fetch(32'h0,  32'h0, 2'b11);
        fetch(32'h34, 32'h0, 2'b11);
        idle(1);

        // Reload after reset makes the word fetchable again.
        load(5'd0, 32'h1234_5678);
        fetch(32'h0, 32'h1234_5678, 2'b00);
        idle(3);

        check("sb_drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
